// File: rtl/des_core.sv
// Iterative DES block cipher: one Feistel round per clock, 16 rounds per block.
// Encrypt or decrypt, with an odd-parity check on every key byte reported alongside the result.
module des_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] plaintext,
  input  logic [63:0] key,
  output logic [63:0] ciphertext,
  output logic        inv_key,
  output logic        busy,
  output logic        done
);

  // Table entries use FIPS numbering (1 = MSB); the first entry is output bit 1.
  localparam logic [63:0][5:0] IP_T = {
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,
    6'd64, 6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7
  };

  localparam logic [63:0][5:0] FP_T = {
    6'd40, 6'd8, 6'd48, 6'd16, 6'd56, 6'd24, 6'd64, 6'd32,
    6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
    6'd38, 6'd6, 6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
    6'd37, 6'd5, 6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
    6'd36, 6'd4, 6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
    6'd35, 6'd3, 6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
    6'd34, 6'd2, 6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
    6'd33, 6'd1, 6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25
  };

  localparam logic [47:0][5:0] E_T = {
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
    6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };

  localparam logic [31:0][5:0] P_T = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  localparam logic [55:0][5:0] PC1_T = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [47:0][5:0] PC2_T = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // S1 first; within a box entries run row 0 col 0 .. row 3 col 15.
  localparam logic [7:0][63:0][3:0] SBOX = {
    4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
    4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
    4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
    4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13,
    4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
    4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
    4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
    4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9,
    4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
    4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
    4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
    4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12,
    4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
    4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
    4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
    4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14,
    4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
    4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
    4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
    4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3,
    4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
    4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
    4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
    4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13,
    4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
    4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
    4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
    4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12,
    4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
    4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
    4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
    4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11
  };

  // FIPS bit n of a W-bit vector lives at index W-n; the 6-bit wrap gives 64-n for free.
  function automatic logic [63:0] perm64(input logic [63:0] x, input logic [63:0][5:0] t);
    logic [63:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int k = 0; k < 64; k++) begin
      idx  = 6'd0 - t[k];
      y[k] = x[idx];
    end
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int k = 0; k < 56; k++) begin
      idx  = 6'd0 - PC1_T[k];
      y[k] = x[idx];
    end
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int k = 0; k < 48; k++) begin
      idx  = 6'd56 - PC2_T[k];
      y[k] = x[idx];
    end
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int k = 0; k < 48; k++) begin
      idx  = 6'd32 - E_T[k];
      y[k] = x[idx[4:0]];
    end
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int k = 0; k < 32; k++) begin
      idx  = 6'd32 - P_T[k];
      y[k] = x[idx[4:0]];
    end
    return y;
  endfunction

  // Row is formed from the outer bits, column from the inner four.
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    logic [5:0]  n;
    x = perm_e(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      n = {b[5], b[0], b[4:1]};
      s[31-4*i -: 4] = SBOX[7-i][~n];
    end
    return perm_p(s);
  endfunction

  logic [31:0] l_q, r_q, l_d, r_d;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [4:0]  cnt_q;
  logic        mode_q, par_q, busy_q, done_q, inv_q;
  logic [63:0] ct_q, ct_d, ip_v;
  logic [55:0] pc1_v;
  logic [47:0] k_v;
  logic        par_d, one_step, no_step;

  always_comb begin
    ip_v  = perm64(plaintext, IP_T);
    pc1_v = perm_pc1(key);
    par_d = 1'b0;
    for (int b = 0; b < 8; b++) par_d = par_d | ~^key[8*b +: 8];

    one_step = (cnt_q == 5'd1) || (cnt_q == 5'd2) || (cnt_q == 5'd9) || (cnt_q == 5'd16);
    no_step  = 1'b0;
    // Decrypt walks the schedule backwards: round 1 uses C0/D0 unrotated (= K16).
    if (mode_q) begin
      no_step  = (cnt_q == 5'd1);
      one_step = (cnt_q == 5'd2) || (cnt_q == 5'd9) || (cnt_q == 5'd16);
      if (no_step) begin
        c_d = c_q;
        d_d = d_q;
      end else if (one_step) begin
        c_d = {c_q[0], c_q[27:1]};
        d_d = {d_q[0], d_q[27:1]};
      end else begin
        c_d = {c_q[1:0], c_q[27:2]};
        d_d = {d_q[1:0], d_q[27:2]};
      end
    end else if (one_step) begin
      c_d = {c_q[26:0], c_q[27]};
      d_d = {d_q[26:0], d_q[27]};
    end else begin
      c_d = {c_q[25:0], c_q[27:26]};
      d_d = {d_q[25:0], d_q[27:26]};
    end

    k_v  = perm_pc2({c_d, d_d});
    l_d  = r_q;
    r_d  = l_q ^ feistel(r_q, k_v);
    ct_d = perm64({r_d, l_d}, FP_T);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      par_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      inv_q  <= 1'b0;
      ct_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          l_q    <= ip_v[63:32];
          r_q    <= ip_v[31:0];
          c_q    <= pc1_v[55:28];
          d_q    <= pc1_v[27:0];
          mode_q <= decrypt;
          par_q  <= par_d;
          cnt_q  <= 5'd1;
          busy_q <= 1'b1;
        end
      end else begin
        l_q <= l_d;
        r_q <= r_d;
        c_q <= c_d;
        d_q <= d_d;
        if (cnt_q == 5'd16) begin
          ct_q   <= ct_d;
          inv_q  <= par_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end
    end
  end

  assign ciphertext = ct_q;
  assign inv_key    = inv_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_des_core.sv
// Directed bench for des_core: published DES vectors, parity flag, start collisions,
// back-to-back start, mid-block reset and encrypt/decrypt round trips.
module tb_des_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] plaintext;
  logic [63:0] key;
  logic [63:0] ciphertext;
  logic        inv_key;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .decrypt    (decrypt),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .inv_key    (inv_key),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one block, scramble the inputs afterwards, and count cycles to done.
  task automatic do_block(input logic dec, input logic [63:0] k, input logic [63:0] p,
                          output logic [63:0] c, output logic iv, output int lat);
    @(negedge clk);
    start = 1'b1; decrypt = dec; key = k; plaintext = p;
    @(posedge clk); #1;
    start = 1'b0; decrypt = ~dec; key = ~k; plaintext = ~p;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    c  = ciphertext;
    iv = inv_key;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c, c2, p;
    logic        iv;
    int          lat, dones, first_done;

    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; plaintext = '0;
    #12;
    chk("reset_ct",   ciphertext, 64'h0);
    chk("reset_inv",  {63'h0, inv_key}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    do_block(1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, c, iv, lat);
    chk("t1_ct",  c, 64'h85E813540F0AB405);
    chk("t1_inv", {63'h0, iv}, 64'h0);
    chk("t1_lat", 64'(lat), 64'd16);
    @(posedge clk); #1;
    chk("t1_done_pulse", {63'h0, done}, 64'h0);
    chk("t1_ct_held", ciphertext, 64'h85E813540F0AB405);

    do_block(1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, c, iv, lat);
    chk("t2_ct",  c, 64'h0);
    chk("t2_inv", {63'h0, iv}, 64'h0);

    do_block(1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, c, iv, lat);
    chk("t3_ct",  c, 64'h0123456789ABCDEF);
    chk("t3_lat", 64'(lat), 64'd16);

    do_block(1'b0, 64'h0E329232EA6D0D72, 64'h8787878787878787, c, iv, lat);
    chk("t4_ct",  c, 64'h0);
    chk("t4_inv", {63'h0, iv}, 64'h1);

    do_block(1'b0, 64'h0123456789ABCDEF, 64'h4E6F772069732074, c, iv, lat);
    chk("nowis_ct",  c, 64'h3FA40E8A984D4815);
    chk("nowis_inv", {63'h0, iv}, 64'h0);

    do_block(1'b0, 64'h0, 64'h0, c, iv, lat);
    chk("zero_ct",  c, 64'h8CA64DE9C1B123A7);
    chk("zero_inv", {63'h0, iv}, 64'h1);

    do_block(1'b1, 64'h0E329232EA6D0D73, 64'h0, c, iv, lat);
    chk("dec0_ct", c, 64'h8787878787878787);

    // Restart attempt mid-block must be ignored.
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; key = 64'h133457799BBCDFF1; plaintext = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first_done = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
      if (cyc == 5) begin
        key = 64'h0E329232EA6D0D73; plaintext = 64'h8787878787878787;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        dones++;
        if (first_done == 0) first_done = cyc;
      end
    end
    chk("t5_done_count", 64'(dones), 64'd1);
    chk("t5_done_cycle", 64'(first_done), 64'd16);
    chk("t5_ct", ciphertext, 64'h85E813540F0AB405);

    // Back-to-back start issued during the done cycle.
    start = 1'b1; decrypt = 1'b0; key = 64'h0E329232EA6D0D73; plaintext = 64'h8787878787878787;
    @(posedge clk); #1;
    start = 1'b0; key = '0; plaintext = '0;
    chk("t5_b2b_busy", {63'h0, busy}, 64'h1);
    chk("t5_b2b_done_low", {63'h0, done}, 64'h0);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t5_b2b_lat", 64'(lat), 64'd16);
    chk("t5_b2b_ct", ciphertext, 64'h0);

    do_block(1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, c, iv, lat);
    chk("pre_rst_ct", c, 64'h85E813540F0AB405);

    // Reset asserted mid-block clears everything at once.
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; key = 64'h133457799BBCDFF1; plaintext = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {63'h0, busy}, 64'h0);
    chk("t6_rst_done", {63'h0, done}, 64'h0);
    chk("t6_rst_ct",   ciphertext, 64'h0);
    dones = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("t6_no_done", 64'(dones), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_block(1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, c, iv, lat);
    chk("t6_recover_ct", c, 64'h0);

    for (int n = 0; n < 1000; n++) begin
      p = {$urandom, $urandom};
      do_block(1'b0, 64'h0E329232EA6D0D73, p, c, iv, lat);
      do_block(1'b1, 64'h0E329232EA6D0D73, c, c2, iv, lat);
      chk("t6_roundtrip", c2, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
